key_tone_scheduler: RTL

//  Shares the single square-wave tone generator between NKEYS piano keys. Each cycle it picks
//  one winning key, loads that key's half-period divisor into the tone counter and drives speaker.

---
 rtl/piano_pkg.sv | 28 ++
 rtl/tone_divider.sv | 26 ++
 rtl/key_tone_scheduler.sv | 114 +++++++++++
 3 files changed

// File: rtl/piano_pkg.sv
// rtl/piano_pkg.sv - note divisor table, scheduler state encoding and note index width
package piano_pkg;

  localparam int NOTE_IDX_W = 3;
  localparam int NUM_NOTES  = 8;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PLAY    = 2'd1,
    ST_GAP     = 2'd2,
    ST_SUSTAIN = 2'd3
  } state_t;

  // Half-period divisors at 25 MHz, C4..C5
  function automatic logic [15:0] note_div(input logic [NOTE_IDX_W-1:0] idx);
    case (idx)
      3'd0:    return 16'd47778;
      3'd1:    return 16'd42566;
      3'd2:    return 16'd37921;
      3'd3:    return 16'd35793;
      3'd4:    return 16'd31888;
      3'd5:    return 16'd28409;
      3'd6:    return 16'd25310;
      default: return 16'd23889;
    endcase
  endfunction

endpackage

// File: rtl/tone_divider.sv
// rtl/tone_divider.sv - half-period counter producing the square wave; restart clears phase and mutes
module tone_divider #(
  parameter int DIV_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             restart,
  input  logic [DIV_W-1:0] div,
  output logic             speaker
);

  logic [DIV_W-1:0] count;

  always_ff @(posedge clk) begin
    if (reset || restart) begin
      count   <= '0;
      speaker <= 1'b0;
    end else if (count == div - DIV_W'(1)) begin
      count   <= '0;
      speaker <= ~speaker;
    end else begin
      count   <= count + DIV_W'(1);
    end
  end

endmodule

// File: rtl/key_tone_scheduler.sv
// rtl/key_tone_scheduler.sv - shares one tone divider among the keys with mute gaps on note changes
// Optional release tail: KEY_TONE_SUSTAIN_EN
module key_tone_scheduler
  import piano_pkg::*;
#(
  parameter int NKEYS          = 8,
  parameter int DIV_W          = 16,
  parameter int GAP_CYCLES     = 256,
  parameter int SUSTAIN_CYCLES = 2500000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NKEYS-1:0]      keys,
  output logic                  speaker,
  output logic                  note_valid,
  output logic [NOTE_IDX_W-1:0] active_note,
  output logic                  busy
);

  localparam int GAP_W = $clog2(GAP_CYCLES + 1);

  if (GAP_CYCLES < 1 || SUSTAIN_CYCLES < 1) begin : g_param_check
    $error("key_tone_scheduler: GAP_CYCLES and SUSTAIN_CYCLES must be >= 1");
  end

  state_t                state, next_state;
  logic [NOTE_IDX_W-1:0] win_idx;
  logic [GAP_W-1:0]      gap_cnt;
  logic                  any_key;
  logic                  gap_done;
  logic                  restart;
  logic                  sounding, stay_sounding;

  assign any_key  = |keys;
  assign gap_done = (gap_cnt == GAP_W'(GAP_CYCLES - 1));

  always_comb begin
    win_idx = '0;
    for (int i = 0; i < NKEYS; i++) begin
      if (keys[i]) win_idx = NOTE_IDX_W'(i);
    end
  end

`ifdef KEY_TONE_SUSTAIN_EN
  localparam int SUS_W = $clog2(SUSTAIN_CYCLES + 1);
  logic [SUS_W-1:0] sus_cnt;
  logic             sus_done;
  assign sus_done = (sus_cnt == SUS_W'(SUSTAIN_CYCLES - 1));
`endif

  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE: if (any_key) next_state = ST_PLAY;
      ST_PLAY: begin
        if (!any_key) begin
`ifdef KEY_TONE_SUSTAIN_EN
          next_state = ST_SUSTAIN;
`else
          next_state = ST_IDLE;
`endif
        end else if (win_idx != active_note) begin
          next_state = ST_GAP;
        end
      end
      ST_GAP: if (gap_done) next_state = any_key ? ST_PLAY : ST_IDLE;
`ifdef KEY_TONE_SUSTAIN_EN
      ST_SUSTAIN: begin
        if (any_key)       next_state = (win_idx == active_note) ? ST_PLAY : ST_GAP;
        else if (sus_done) next_state = ST_IDLE;
      end
`endif
      default: next_state = ST_IDLE;
    endcase
  end

  // Phase is kept only while moving between PLAY and SUSTAIN; every other move restarts muted
  assign sounding      = (state == ST_PLAY) || (state == ST_SUSTAIN);
  assign stay_sounding = (next_state == ST_PLAY) || (next_state == ST_SUSTAIN);
  assign restart       = !(sounding && stay_sounding);

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_IDLE;
      active_note <= '0;
      gap_cnt     <= '0;
    end else begin
      state <= next_state;
      if (next_state == ST_PLAY && !sounding) active_note <= win_idx;
      gap_cnt <= (state == ST_GAP && next_state == ST_GAP) ? gap_cnt + GAP_W'(1) : '0;
    end
  end

`ifdef KEY_TONE_SUSTAIN_EN
  always_ff @(posedge clk) begin
    if (reset) sus_cnt <= '0;
    else       sus_cnt <= (state == ST_SUSTAIN && next_state == ST_SUSTAIN) ? sus_cnt + SUS_W'(1) : '0;
  end
`endif

  assign note_valid = sounding;
  assign busy       = (state != ST_IDLE);

  tone_divider #(
    .DIV_W(DIV_W)
  ) u_tone_divider (
    .clk    (clk),
    .reset  (reset),
    .restart(restart),
    .div    (DIV_W'(note_div(active_note))),
    .speaker(speaker)
  );

endmodule
